switch_debouncer: RTL and testbench

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

---
 rtl/switch_debouncer_pkg.sv | 14 +
 rtl/switch_debouncer_if.sv | 20 ++
 rtl/switch_debouncer_tick_gen.sv | 23 ++
 rtl/switch_debouncer.sv | 92 +++++++++
 tb/tb_switch_debouncer.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/switch_debouncer_pkg.sv
// Shared state encodings and default timing for the switch debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_e;

  localparam int unsigned TICK_BITS_DEF    = 19;
  localparam int unsigned STABLE_TICKS_DEF = 3;

endpackage

// File: rtl/switch_debouncer_if.sv
// Raw switch in, debounced level and rise pulse out.
interface switch_debouncer_if;

  logic sw;
  logic db_level;
  logic db_tick;

  modport master (
    output sw,
    input  db_level,
    input  db_tick
  );

  modport slave (
    input  sw,
    output db_level,
    output db_tick
  );

endinterface

// File: rtl/switch_debouncer_tick_gen.sv
// Free-running sample-tick generator, pulses when the count is all-ones.
module tick_gen
  import debounce_pkg::*;
#(
  parameter int unsigned TICK_BITS = TICK_BITS_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic m_tick
);

  logic [TICK_BITS-1:0] cnt_q;
  logic [TICK_BITS-1:0] cnt_d;

  assign cnt_d  = cnt_q + 1'b1;
  assign m_tick = &cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces a bouncing switch: level must persist STABLE_TICKS sample ticks.
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned TICK_BITS    = TICK_BITS_DEF,
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  switch_debouncer_if.slave  bus
);

  localparam logic [3:0] LAST = 4'(STABLE_TICKS - 1);

  logic [1:0] sync_q;
  logic       sw_sync;
  logic       m_tick;
  state_e     state_q;
  state_e     state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       db_tick_q;
  logic       db_tick_d;

  assign sw_sync = sync_q[1];

  tick_gen #(
    .TICK_BITS (TICK_BITS)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .m_tick (m_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      state_q   <= ZERO;
      cnt_q     <= '0;
      db_tick_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], bus.sw};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      db_tick_q <= db_tick_d;
    end
  end

  // A reverting level beats a coincident tick in either WAIT state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ZERO: begin
        if (sw_sync) begin
          state_d = WAIT1;
          cnt_d   = '0;
        end
      end
      WAIT1: begin
        if (!sw_sync) begin
          state_d = ZERO;
        end else if (m_tick) begin
          if (cnt_q == LAST) state_d = ONE;
          else               cnt_d   = cnt_q + 4'd1;
        end
      end
      ONE: begin
        if (!sw_sync) begin
          state_d = WAIT0;
          cnt_d   = '0;
        end
      end
      WAIT0: begin
        if (sw_sync) begin
          state_d = ONE;
        end else if (m_tick) begin
          if (cnt_q == LAST) state_d = ZERO;
          else               cnt_d   = cnt_q + 4'd1;
        end
      end
      default: state_d = ZERO;
    endcase
  end

  always_comb begin
    db_tick_d    = (state_q == WAIT1) && (state_d == ONE);
    bus.db_level = (state_q == ONE) || (state_q == WAIT0);
    bus.db_tick  = db_tick_q;
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench: expected level edges queued at stimulus, popped on edges.
module tb_switch_debouncer;

  typedef struct {
    logic lvl;
    logic tick;
    int   lo;
    int   hi;
  } ev_t;

  logic clk;
  logic reset;
  ev_t  exp_q[$];
  int   n_cmp;
  int   n_bad;
  int   cyc;
  int   t0;
  int   nticks;
  logic prev_lvl;
  logic prev_tick;

  switch_debouncer_if bus_if ();

  switch_debouncer #(
    .TICK_BITS    (2),
    .STABLE_TICKS (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic v);
    @(negedge clk);
    bus_if.sw = v;
    t0 = cyc + 1;
  endtask

  task automatic expect_edge(input logic lvl, input logic tick,
                             input int lo, input int hi);
    ev_t e;
    e.lvl  = lvl;
    e.tick = tick;
    e.lo   = lo;
    e.hi   = hi;
    exp_q.push_back(e);
  endtask

  initial begin
    cyc       = 0;
    prev_lvl  = 1'b0;
    prev_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        chk("rst_lvl", int'(bus_if.db_level), 0);
        chk("rst_tick", int'(bus_if.db_tick), 0);
      end
      if (bus_if.db_tick) begin
        nticks++;
        chk("tick_wide", int'(prev_tick), 0);
        if (!(bus_if.db_level && !prev_lvl))
          chk("tick_spur", int'(bus_if.db_tick), 0);
      end
      if (bus_if.db_level !== prev_lvl) begin
        if (exp_q.size() == 0) begin
          chk("unexp_edge", int'(bus_if.db_level), int'(prev_lvl));
        end else begin
          ev_t e;
          int  lat;
          e   = exp_q.pop_front();
          lat = cyc - t0;
          chk("edge_lvl", int'(bus_if.db_level), int'(e.lvl));
          chk("edge_tick", int'(bus_if.db_tick), int'(e.tick));
          chk("edge_lat_ok", int'(lat >= e.lo && lat <= e.hi), 1);
          if (lat < e.lo || lat > e.hi)
            $display("  latency %0d window %0d..%0d", lat, e.lo, e.hi);
        end
      end
      prev_lvl  = bus_if.db_level;
      prev_tick = bus_if.db_tick;
    end
  end

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    nticks    = 0;
    t0        = 0;
    bus_if.sw = 1'b0;
    reset     = 1'b1;
    cycles(3);
    reset = 1'b0;

    cycles(40);
    chk("idle_lvl", int'(bus_if.db_level), 0);

    drive(1'b1);
    expect_edge(1'b1, 1'b1, 11, 14);
    cycles(30);
    chk("rise_done", exp_q.size(), 0);
    chk("rise_lvl", int'(bus_if.db_level), 1);

    drive(1'b0);
    cycles(4);
    drive(1'b1);
    cycles(30);
    chk("glitch_lvl", int'(bus_if.db_level), 1);

    drive(1'b0);
    expect_edge(1'b0, 1'b0, 11, 14);
    cycles(30);
    chk("fall_done", exp_q.size(), 0);
    chk("fall_lvl", int'(bus_if.db_level), 0);

    for (int i = 0; i < 12; i++) begin
      drive(~i[0]);
      cycles(2);
    end
    drive(1'b0);
    cycles(30);
    chk("bounce_lvl", int'(bus_if.db_level), 0);

    drive(1'b1);
    cycles(5);
    reset = 1'b1;
    cycles(3);
    chk("rstw_lvl", int'(bus_if.db_level), 0);
    reset = 1'b0;
    t0 = cyc + 1;
    expect_edge(1'b1, 1'b1, 11, 14);
    cycles(30);
    chk("rstw_done", exp_q.size(), 0);
    chk("rstw_lvl_hi", int'(bus_if.db_level), 1);

    chk("tick_total", nticks, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
